// File: rtl/bin2bcd_disp.sv
// rtl/bin2bcd_disp.sv - sequential double-dabble binary-to-BCD converter driving three 7-segment digits
// Shows the last accepted value in decimal with leading-zero blanking, or "Err" when upstream flagged an error.
module bin2bcd_disp #(
  parameter int WIDTH = 8
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic [WIDTH-1:0] BIN,
  input  logic             START,
  input  logic             ERR_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [11:0]      BCD,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2
);

  localparam int SW = 12 + WIDTH;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

  state_t          state;
  logic [SW-1:0]   sr;
  logic [3:0]      cnt;
  logic            err_pend;
  logic [SW-1:0]   sr_adj;
  logic [SW-1:0]   sr_next;
  logic [3:0]      dig_h;
  logic [3:0]      dig_t;
  logic [3:0]      dig_o;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Only the three BCD nibbles are adjusted; the binary tail shifts out untouched.
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < 3; i++) begin
      if (sr[WIDTH+4*i +: 4] >= 4'd5)
        sr_adj[WIDTH+4*i +: 4] = sr[WIDTH+4*i +: 4] + 4'd3;
    end
    sr_next = {sr_adj[SW-2:0], 1'b0};
  end

  assign dig_h = sr[SW-1 -: 4];
  assign dig_t = sr[SW-5 -: 4];
  assign dig_o = sr[SW-9 -: 4];

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      err_pend <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      BCD      <= 12'h000;
      HEX0     <= 7'b1000000;
      HEX1     <= SEG_BLANK;
      HEX2     <= SEG_BLANK;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            BUSY <= 1'b1;
            if (ERR_IN) begin
              err_pend <= 1'b1;
              state    <= FIN;
            end else begin
              err_pend <= 1'b0;
              sr       <= {12'h000, BIN};
              cnt      <= 4'(WIDTH);
              state    <= SHIFT;
            end
          end
        end
        SHIFT: begin
          sr  <= sr_next;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1)
            state <= FIN;
        end
        FIN: begin
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= IDLE;
          if (err_pend) begin
            ERR  <= 1'b1;
            HEX2 <= SEG_E;
            HEX1 <= SEG_R;
            HEX0 <= SEG_R;
          end else begin
            ERR  <= 1'b0;
            BCD  <= {dig_h, dig_t, dig_o};
            HEX2 <= (dig_h == 4'd0) ? SEG_BLANK : seg7(dig_h);
            HEX1 <= (dig_h == 4'd0 && dig_t == 4'd0) ? SEG_BLANK : seg7(dig_t);
            HEX0 <= seg7(dig_o);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bin2bcd_disp.md
Name: bin2bcd_disp

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one iteration per clock.
- Drives three 7-segment displays (HEX2..HEX0) with leading-zero blanking.
- Sits directly downstream of the two-digit decimal-to-binary entry stage. It takes that stage's binary result plus its error indication and shows the value back in decimal, or shows "Err".

Parameters:
- WIDTH, 8, width of binary input. Legal range 4..9, so that 3 BCD digits always suffice (maximum value 511).

Ports:
- CLOCK_50  input   1   system clock, rising-edge.
- RESET     input   1   asynchronous, active-high reset.
- BIN       input   WIDTH  binary value to convert, sampled on accepted START.
- START     input   1   request; accepted only in IDLE.
- ERR_IN    input   1   upstream error flag, sampled together with BIN on accepted START.
- BUSY      output  1   high while a request is in progress (SHIFT or FIN state).
- DONE      output  1   one-cycle pulse when outputs update.
- ERR       output  1   registered; high when the last accepted request had ERR_IN=1.
- BCD       output  12  registered result, digits [11:8]=hundreds, [7:4]=tens, [3:0]=ones.
- HEX0      output  7   ones digit segments.
- HEX1      output  7   tens digit segments.
- HEX2      output  7   hundreds digit segments.

Behaviour:
- Reset values (asynchronous, immediate):
  - State IDLE; BUSY=0, DONE=0, ERR=0, BCD=12'h000.
  - HEX0=7'b1000000 ("0"); HEX1=HEX2=7'b1111111 (blank).
  - Internal shift register and counter cleared. Reset mid-conversion aborts it; no DONE is produced.
- Segment encoding: active-low, bit6..bit0 = g,f,e,d,c,b,a.
  - Digits 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - Blank = 1111111. 'E' = 0000110. 'r' = 0101111.
- State machine (IDLE, SHIFT, FIN):
  - IDLE, START=1, ERR_IN=0: load shift register {12'h000, BIN}, counter=WIDTH, go to SHIFT.
  - IDLE, START=1, ERR_IN=1: skip conversion, set an internal error latch, go directly to FIN.
  - SHIFT, each cycle: for every BCD nibble >=5 add 3 (all nibbles adjusted in parallel), then shift the whole register left by 1, then decrement counter. After the WIDTH-th shift, go to FIN.
  - FIN (one cycle): register outputs, DONE=1, return to IDLE.
    - Normal case: BCD=scratch digits, ERR=0, HEX updated.
    - Error case: ERR=1, BCD held at its previous value, HEX2='E', HEX1='r', HEX0='r'.
- Latency: START accepted on clock edge N gives DONE high during the cycle after edge N+WIDTH+1 for a normal request, and after edge N+1 for an error request.
  - BUSY rises after edge N and falls together with DONE.
- START while BUSY=1 is ignored entirely; it is not queued. START held high continuously re-triggers on each return to IDLE.
- BIN and ERR_IN changes after acceptance have no effect on the request in progress.
- Outputs BCD, ERR and HEX* change only in FIN (or on reset) and hold between requests.
- Leading-zero blanking (normal case):
  - HEX2 blank if hundreds=0.
  - HEX1 blank if hundreds=0 and tens=0.
  - HEX0 always shows its digit.
- Width rule: the adjust is applied only to the 12 BCD bits; the binary part shifts out unchanged. No overflow is possible within the legal WIDTH range.

Test Plan:
- Reset, then BIN=8'd127, START pulse: DONE exactly 9 cycles after the accepting edge; BCD=12'h127; HEX2=1111001, HEX1=0100100, HEX0=1111000; ERR=0.
- BIN=0, START: BCD=12'h000; HEX0=1000000; HEX1=HEX2=1111111.
- BIN=255, then BIN=9: first BCD=12'h255; second BCD=12'h009 with HEX1 and HEX2 blank. BIN=10 gives HEX2 blank and HEX1 showing "1".
- BIN=200, START, then a second START and BIN changed to 5 at cycle 3: result is 12'h200, exactly one DONE pulse is produced, and BUSY stays high throughout.
- ERR_IN=1 with START: DONE 1 cycle later; ERR=1; HEX2=0000110, HEX1=HEX0=0101111; BCD retains the previous value. A following clean request for 42 clears ERR and shows "42".
- Assert RESET at cycle 4 of a conversion of 99: BUSY=0 immediately, no DONE appears, outputs show reset values. A new START after release converts correctly.
